mipi_lane_pkt_ctrl: RTL

Per-lane packet sequencer placed directly after the byte bit-slip aligner in the MIPI receive path. It drives the aligner's frame_start window and waits for the sync indication. It then parses the 4-byte CSI-2 packet header, streams payload bytes with first/last flags, captures the 2-byte CRC, and returns to idle. It is also responsible for detecting timeout and early-end errors.

---
 rtl/mipi_lane_pkt_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mipi_lane_pkt_ctrl.sv
// Per-lane CSI-2 packet sequencer sitting behind the byte bit-slip aligner.
// Opens the aligner capture window, waits for sync, parses the 4-byte header,
// streams payload with first/last flags, captures the CRC and flags
// timeout / early-end / bad word-count conditions.
module mipi_lane_pkt_ctrl #(
  parameter int unsigned    SOT_TIMEOUT = 32,
  parameter int unsigned    WCW         = 16,
  parameter logic [WCW-1:0] MAX_WC      = WCW'(4096)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           hs_active,
  input  logic           byte_gate,
  input  logic           found_sot,
  input  logic [7:0]     actual_byte,
  output logic           frame_start,
  output logic           hdr_valid,
  output logic [7:0]     data_id,
  output logic [WCW-1:0] word_count,
  output logic [7:0]     ecc,
  output logic           pay_valid,
  output logic [7:0]     pay_byte,
  output logic           pay_first,
  output logic           pay_last,
  output logic [15:0]    crc,
  output logic           pkt_done,
  output logic           err_timeout,
  output logic           err_early_end,
  output logic           err_wc
);

  localparam int unsigned HCW = $clog2(SOT_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StHunt, StHdr, StPayload, StCrc, StWaitLp} state_e;

  state_e state_q, state_d;

  logic           byte_vld_q, hs_q, hs_rise;
  logic [HCW-1:0] hunt_q, hunt_d, hunt_inc;
  logic [1:0]     hdr_idx_q, hdr_idx_d;
  logic [7:0]     hdr0_q, hdr0_d, hdr1_q, hdr1_d, hdr2_q, hdr2_d;
  logic [WCW-1:0] hdr_wc;
  logic [WCW-1:0] remaining_q, remaining_d;
  logic           first_q, first_d;
  logic           crc_hi_q, crc_hi_d;

  logic           hdr_valid_q, hdr_valid_d;
  logic [7:0]     data_id_q, data_id_d, ecc_q, ecc_d;
  logic [WCW-1:0] word_count_q, word_count_d;
  logic           pay_valid_q, pay_valid_d, pay_first_q, pay_first_d, pay_last_q, pay_last_d;
  logic [7:0]     pay_byte_q, pay_byte_d;
  logic [15:0]    crc_q, crc_d;
  logic           pkt_done_q, pkt_done_d;
  logic           err_timeout_q, err_timeout_d;
  logic           err_early_end_q, err_early_end_d;
  logic           err_wc_q, err_wc_d;

  assign hs_rise  = hs_active & ~hs_q;
  // Saturating hunt counter increment.
  assign hunt_inc = (hunt_q == HCW'(SOT_TIMEOUT)) ? hunt_q : hunt_q + HCW'(1);
  assign hdr_wc   = WCW'({hdr2_q, hdr1_q});

  // Offset is held while a packet is in flight, cleared otherwise.
  assign frame_start = (state_q == StHunt) || (state_q == StHdr) ||
                       (state_q == StPayload) || (state_q == StCrc);

  assign hdr_valid     = hdr_valid_q;
  assign data_id       = data_id_q;
  assign word_count    = word_count_q;
  assign ecc           = ecc_q;
  assign pay_valid     = pay_valid_q;
  assign pay_byte      = pay_byte_q;
  assign pay_first     = pay_first_q;
  assign pay_last      = pay_last_q;
  assign crc           = crc_q;
  assign pkt_done      = pkt_done_q;
  assign err_timeout   = err_timeout_q;
  assign err_early_end = err_early_end_q;
  assign err_wc        = err_wc_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    hunt_d          = hunt_q;
    hdr_idx_d       = hdr_idx_q;
    hdr0_d          = hdr0_q;
    hdr1_d          = hdr1_q;
    hdr2_d          = hdr2_q;
    remaining_d     = remaining_q;
    first_d         = first_q;
    crc_hi_d        = crc_hi_q;
    data_id_d       = data_id_q;
    word_count_d    = word_count_q;
    ecc_d           = ecc_q;
    pay_byte_d      = pay_byte_q;
    crc_d           = crc_q;
    hdr_valid_d     = 1'b0;
    pay_valid_d     = 1'b0;
    pay_first_d     = 1'b0;
    pay_last_d      = 1'b0;
    pkt_done_d      = 1'b0;
    err_timeout_d   = 1'b0;
    err_early_end_d = 1'b0;
    err_wc_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        hunt_d = '0;
        if (hs_rise) state_d = StHunt;
      end
      StHunt: begin
        if (!hs_active) begin
          state_d = StIdle;
        end else if (byte_vld_q) begin
          if (found_sot) begin
            state_d   = StHdr;
            hdr_idx_d = '0;
          end else begin
            hunt_d = hunt_inc;
            if (hunt_inc == HCW'(SOT_TIMEOUT)) begin
              err_timeout_d = 1'b1;
              state_d       = StWaitLp;
            end
          end
        end
      end
      StHdr: begin
        if (!hs_active) begin
          err_early_end_d = 1'b1;
          state_d         = StIdle;
        end else if (byte_vld_q) begin
          case (hdr_idx_q)
            2'd0: begin hdr0_d = actual_byte; hdr_idx_d = 2'd1; end
            2'd1: begin hdr1_d = actual_byte; hdr_idx_d = 2'd2; end
            2'd2: begin hdr2_d = actual_byte; hdr_idx_d = 2'd3; end
            default: begin
              data_id_d    = hdr0_q;
              word_count_d = hdr_wc;
              ecc_d        = actual_byte;
              hdr_valid_d  = 1'b1;
              if (hdr0_q[5:0] < 6'h10) begin
                pkt_done_d = 1'b1;
                state_d    = StWaitLp;
              end else if ((hdr_wc == '0) || (hdr_wc > MAX_WC)) begin
                err_wc_d = 1'b1;
                state_d  = StWaitLp;
              end else begin
                remaining_d = hdr_wc;
                first_d     = 1'b1;
                state_d     = StPayload;
              end
            end
          endcase
        end
      end
      StPayload: begin
        if (!hs_active) begin
          err_early_end_d = 1'b1;
          state_d         = StIdle;
        end else if (byte_vld_q) begin
          pay_valid_d = 1'b1;
          pay_byte_d  = actual_byte;
          pay_first_d = first_q;
          pay_last_d  = (remaining_q == WCW'(1));
          first_d     = 1'b0;
          if (remaining_q != '0) remaining_d = remaining_q - WCW'(1);
          if (remaining_q <= WCW'(1)) begin
            crc_hi_d = 1'b0;
            state_d  = StCrc;
          end
        end
      end
      StCrc: begin
        if (!hs_active) begin
          err_early_end_d = 1'b1;
          state_d         = StIdle;
        end else if (byte_vld_q) begin
          if (!crc_hi_q) begin
            crc_d[7:0] = actual_byte;
            crc_hi_d   = 1'b1;
          end else begin
            crc_d[15:8] = actual_byte;
            crc_hi_d    = 1'b0;
            pkt_done_d  = 1'b1;
            state_d     = StWaitLp;
          end
        end
      end
      StWaitLp: begin
        if (!hs_active) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StIdle;
      byte_vld_q      <= 1'b0;
      hs_q            <= 1'b0;
      hunt_q          <= '0;
      hdr_idx_q       <= '0;
      hdr0_q          <= '0;
      hdr1_q          <= '0;
      hdr2_q          <= '0;
      remaining_q     <= '0;
      first_q         <= 1'b0;
      crc_hi_q        <= 1'b0;
      hdr_valid_q     <= 1'b0;
      data_id_q       <= '0;
      word_count_q    <= '0;
      ecc_q           <= '0;
      pay_valid_q     <= 1'b0;
      pay_byte_q      <= '0;
      pay_first_q     <= 1'b0;
      pay_last_q      <= 1'b0;
      crc_q           <= '0;
      pkt_done_q      <= 1'b0;
      err_timeout_q   <= 1'b0;
      err_early_end_q <= 1'b0;
      err_wc_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_vld_q      <= byte_gate;
      hs_q            <= hs_active;
      hunt_q          <= hunt_d;
      hdr_idx_q       <= hdr_idx_d;
      hdr0_q          <= hdr0_d;
      hdr1_q          <= hdr1_d;
      hdr2_q          <= hdr2_d;
      remaining_q     <= remaining_d;
      first_q         <= first_d;
      crc_hi_q        <= crc_hi_d;
      hdr_valid_q     <= hdr_valid_d;
      data_id_q       <= data_id_d;
      word_count_q    <= word_count_d;
      ecc_q           <= ecc_d;
      pay_valid_q     <= pay_valid_d;
      pay_byte_q      <= pay_byte_d;
      pay_first_q     <= pay_first_d;
      pay_last_q      <= pay_last_d;
      crc_q           <= crc_d;
      pkt_done_q      <= pkt_done_d;
      err_timeout_q   <= err_timeout_d;
      err_early_end_q <= err_early_end_d;
      err_wc_q        <= err_wc_d;
    end
  end

endmodule
